// File: rtl/arbiter_rr_locked_multi.sv
// Round-robin arbiter granting up to G of N requesters at once. Each grant
// stays locked to its owner until the owner pulses done or drops req. A
// one-hot pointer marks the lowest-priority requester; the search for new
// owners starts just above it and wraps around.
module arbiter_rr_locked_multi #(
  parameter int N                = 8,
  parameter int G                = 2,
  parameter int INIT_LOWEST_PRIO = N - 1,
  parameter int EXCLUDE_LOWEST   = 1,
  parameter int AUTO_ROTATE      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req,
  input  logic [N-1:0]             done,
  input  logic                     shift,
  output logic [N-1:0]             grant,
  output logic [$clog2(G+1)-1:0]   grant_count,
  output logic                     full,
  output logic [N-1:0]             lowest_prio
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(G + 1);
  localparam int SW = $clog2(N + 1);
  localparam logic [N-1:0] PTR_INIT = {{(N-1){1'b0}}, 1'b1} << INIT_LOWEST_PRIO;

  logic [N-1:0]  own;
  logic [N-1:0]  ptr;
  logic [N-1:0]  rel;
  logic [N-1:0]  kept;
  logic [N-1:0]  elig;
  logic [N-1:0]  new_grant;
  logic [N-1:0]  own_next;
  logic [N-1:0]  ptr_next;
  logic [SW-1:0] free_cnt;
  logic [SW-1:0] taken;
  logic [IW-1:0] ptr_idx;
  logic [IW-1:0] sel;
  logic [IW-1:0] last_idx;
  logic          any_new;

  function automatic logic [SW-1:0] popcount(input logic [N-1:0] v);
    logic [SW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + SW'(v[i]);
    return c;
  endfunction

  // Release, capacity, rotating search for new owners and next pointer
  always_comb begin
    rel       = own & (done | ~req);
    kept      = own & ~rel;
    // kept never exceeds G because own never holds more than G bits
    free_cnt  = SW'(G) - popcount(kept);
    elig      = req & ~own & ~rel;
    if (EXCLUDE_LOWEST != 0) elig = elig & ~ptr;

    ptr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr[i]) ptr_idx = IW'(i);
    end

    new_grant = '0;
    taken     = '0;
    last_idx  = ptr_idx;
    any_new   = 1'b0;
    sel       = '0;
    // k = N lands on the pointer itself; it is masked out of elig when excluded
    for (int k = 1; k <= N; k++) begin
      sel = IW'((int'(ptr_idx) + k) % N);
      if (elig[sel] && (taken < free_cnt)) begin
        new_grant[sel] = 1'b1;
        taken          = taken + SW'(1);
        last_idx       = sel;
        any_new        = 1'b1;
      end
    end

    own_next = kept | new_grant;

    ptr_next = ptr;
    if (AUTO_ROTATE != 0) begin
      if (any_new) begin
        ptr_next           = '0;
        ptr_next[last_idx] = 1'b1;
      end
    end else if (shift) begin
      ptr_next = {ptr[N-2:0], ptr[N-1]};
    end
  end

  // Ownership and priority pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      own <= '0;
      ptr <= PTR_INIT;
    end else begin
      own <= own_next;
      ptr <= ptr_next;
    end
  end

  assign grant       = own;
  assign lowest_prio = ptr;
  assign grant_count = CW'(popcount(own));
  assign full        = (grant_count == CW'(G));

  // Never more owners than lock slots
  a_capacity: assert property (@(posedge clk) disable iff (rst)
    popcount(own) <= SW'(G));

  // The lowest-priority index never gains a new grant when excluded
  a_exclude: assert property (@(posedge clk) disable iff (rst)
    (EXCLUDE_LOWEST == 0) || ((new_grant & ptr) == '0));

endmodule

// File: tb/tb_arbiter_rr_locked_multi.sv
// Bench for arbiter_rr_locked_multi: three instances (manual/exclude,
// auto/exclude, manual/search-last with a different reset pointer) share
// one stimulus stream. A reference model predicts every registered output;
// predictions are queued and a monitor compares them after each edge.
module tb_arbiter_rr_locked_multi;
  localparam int N    = 8;
  localparam int G    = 2;
  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift;
  logic [7:0] req;
  logic [7:0] done;

  logic [7:0] g    [NDUT];
  logic [7:0] lp   [NDUT];
  logic [1:0] cnt  [NDUT];
  logic       full [NDUT];

  typedef struct packed {
    logic [NDUT-1:0][7:0] g;
    logic [NDUT-1:0][7:0] lp;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] m_own [NDUT];
  int         m_ptr [NDUT];

  always #5 clk = ~clk;

  arbiter_rr_locked_multi #(.N(N), .G(G), .INIT_LOWEST_PRIO(7), .EXCLUDE_LOWEST(1), .AUTO_ROTATE(0)) u_man (
    .clk(clk), .rst(rst), .req(req), .done(done), .shift(shift),
    .grant(g[0]), .grant_count(cnt[0]), .full(full[0]), .lowest_prio(lp[0]));

  arbiter_rr_locked_multi #(.N(N), .G(G), .INIT_LOWEST_PRIO(7), .EXCLUDE_LOWEST(1), .AUTO_ROTATE(1)) u_auto (
    .clk(clk), .rst(rst), .req(req), .done(done), .shift(shift),
    .grant(g[1]), .grant_count(cnt[1]), .full(full[1]), .lowest_prio(lp[1]));

  arbiter_rr_locked_multi #(.N(N), .G(G), .INIT_LOWEST_PRIO(3), .EXCLUDE_LOWEST(0), .AUTO_ROTATE(0)) u_incl (
    .clk(clk), .rst(rst), .req(req), .done(done), .shift(shift),
    .grant(g[2]), .grant_count(cnt[2]), .full(full[2]), .lowest_prio(lp[2]));

  function automatic int cfg_excl(input int j);
    return (j == 2) ? 0 : 1;
  endfunction

  function automatic int cfg_auto(input int j);
    return (j == 1) ? 1 : 0;
  endfunction

  function automatic int cfg_init(input int j);
    return (j == 2) ? 3 : 7;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: build the search order as a list of indices, release first,
  // then hand out the free slots to eligible requesters in that order.
  task automatic model_step(input int j, input logic r, input logic [7:0] rq,
                            input logic [7:0] dn, input logic sh);
    logic [7:0] rel;
    logic [7:0] newg;
    int         free;
    int         last;
    int         order[$];
    if (r) begin
      m_own[j] = 8'h00;
      m_ptr[j] = cfg_init(j);
      return;
    end
    rel  = m_own[j] & (dn | ~rq);
    free = G - $countones(m_own[j] & ~rel);
    for (int k = 1; k < N; k++) order.push_back((m_ptr[j] + k) % N);
    if (cfg_excl(j) == 0) order.push_back(m_ptr[j]);
    newg = 8'h00;
    last = -1;
    foreach (order[k]) begin
      if (free > 0 && rq[order[k]] && !m_own[j][order[k]]) begin
        newg[order[k]] = 1'b1;
        free--;
        last = order[k];
      end
    end
    m_own[j] = (m_own[j] & ~rel) | newg;
    if (cfg_auto(j) != 0) begin
      if (last >= 0) m_ptr[j] = last;
    end else if (sh) begin
      m_ptr[j] = (m_ptr[j] + 1) % N;
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] rq, input logic [7:0] dn, input logic sh);
    exp_t e;
    @(negedge clk);
    rst   = r;
    req   = rq;
    done  = dn;
    shift = sh;
    for (int j = 0; j < NDUT; j++) begin
      model_step(j, r, rq, dn, sh);
      e.g[j]  = m_own[j];
      e.lp[j] = 8'(1 << m_ptr[j]);
    end
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every instance against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int j = 0; j < NDUT; j++) begin
          check8($sformatf("grant%0d", j), g[j], e.g[j]);
          check8($sformatf("lowest_prio%0d", j), lp[j], e.lp[j]);
          check8($sformatf("grant_count%0d", j), {6'b0, cnt[j]}, 8'($countones(e.g[j])));
          check8($sformatf("full%0d", j), {7'b0, full[j]}, {7'b0, ($countones(e.g[j]) == G)});
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    req   = 8'h00;
    done  = 8'h00;
    shift = 1'b0;

    // Reset state
    drive(1'b1, 8'h00, 8'h00, 1'b0); settle();
    check8("rst_grant", g[0], 8'h00);
    check8("rst_count", {6'b0, cnt[0]}, 8'h00);
    check8("rst_full", {7'b0, full[0]}, 8'h00);
    check8("rst_lp", lp[0], 8'h80);

    // All requesting: two lowest indices above the pointer win and hold
    drive(1'b0, 8'hFF, 8'h00, 1'b0); settle();
    check8("ff_grant", g[0], 8'h03);
    check8("ff_full", {7'b0, full[0]}, 8'h01);
    repeat (10) drive(1'b0, 8'hFF, 8'h00, 1'b0);
    settle();
    check8("ff_hold", g[0], 8'h03);

    // Owner 0 finishes: its slot goes to index 2 on the same edge
    drive(1'b0, 8'hFF, 8'h01, 1'b0); settle();
    check8("done_grant", g[0], 8'h06);
    check8("done_count", {6'b0, cnt[0]}, 8'h02);

    // Request only at the pointer: starves until shift
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    repeat (5) drive(1'b0, 8'h80, 8'h00, 1'b0);
    settle();
    check8("starve_grant", g[0], 8'h00);
    drive(1'b0, 8'h80, 8'h00, 1'b1); settle();
    check8("shift_lp", lp[0], 8'h01);
    check8("shift_grant", g[0], 8'h00);
    drive(1'b0, 8'h80, 8'h00, 1'b0); settle();
    check8("shift_late_grant", g[0], 8'h80);

    // Auto rotation: pointer follows the last new grant (index 1), so the
    // next search starts at 2 and index 1 is the excluded one
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0); settle();
    check8("auto_grant", g[1], 8'h03);
    check8("auto_lp", lp[1], 8'h02);
    drive(1'b0, 8'hFF, 8'h03, 1'b0); settle();
    check8("auto_regrant", g[1], 8'h0C);
    check8("auto_lp2", lp[1], 8'h08);

    // Reset while locked drops everything
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    drive(1'b1, 8'hFD, 8'h00, 1'b0); settle();
    check8("midrst_grant", g[0], 8'h00);
    check8("midrst_lp", lp[0], 8'h80);

    // Abort by dropping req: slot reused by index 2
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    drive(1'b0, 8'hFD, 8'h00, 1'b0); settle();
    check8("abort_grant", g[0], 8'h05);

    // Random traffic, checked entirely through the scoreboard
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 99) == 0),
            8'($urandom | $urandom),
            8'($urandom & $urandom),
            ($urandom_range(0, 4) == 0));
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #3;
    check8("drain", 8'(q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
